// File: rtl/pingpong_frame_buffer.sv
// -----------------------------------------------------------------------------
// pingpong_frame_buffer
//
// Double-buffered pixel store. The producer writes the back bank
// (~front_sel). The display scan reads the front bank (front_sel). A swap
// request exchanges the two banks on the next cycle with no read, write or
// clear activity, so the display never observes a partially written frame.
// Read data arrives as split R/G/B channels one cycle after rd_en.
//
// Optional feature (macro FB_CLEAR_EN): a clear engine that zeroes the back
// bank one word per cycle. Without the macro, clr_req is ignored and clr_busy
// is tied low.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   wr_en      write strobe into the back bank
//   wr_addr    write pixel address (>= DEPTH is dropped)
//   wr_data    pixel word {B, G, R}, each CH_W bits
//   wr_be      per-channel write enable (bit0 R, bit1 G, bit2 B)
//   rd_en      read strobe from the front bank
//   rd_addr    read pixel address (>= DEPTH reads zero and flags rd_oob)
//   rd_r/g/b   channels of the last read
//   rd_valid   1-cycle pulse when the read outputs update
//   rd_oob     1-cycle pulse with rd_valid for an out-of-range read
//   swap_req   request a bank exchange
//   swap_ack   1-cycle pulse in the cycle after the exchange
//   front_sel  bank currently displayed
//   clr_req    clear-engine start (FB_CLEAR_EN only)
//   clr_busy   clear engine active (FB_CLEAR_EN only)
// -----------------------------------------------------------------------------
module pingpong_frame_buffer #(
    parameter int CH_W   = 8,
    parameter int DEPTH  = 10000,
    parameter int ADDR_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic [2:0]          wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CH_W-1:0]     rd_r,
    output logic [CH_W-1:0]     rd_g,
    output logic [CH_W-1:0]     rd_b,
    output logic                rd_valid,
    output logic                rd_oob,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                front_sel,
    input  logic                clr_req,
    output logic                clr_busy
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        PEND
    } swap_state_t;

    swap_state_t       state;
    logic [3*CH_W-1:0] mem [2][DEPTH];

    logic              back_sel;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_fire;
    logic              swap_fire;
    logic              clr_wr;
    logic [IDX_W-1:0]  clr_cnt;

    assign back_sel    = ~front_sel;
    assign wr_in_range = (wr_addr <= LAST_ADDR);
    assign rd_in_range = (rd_addr <= LAST_ADDR);
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];

    // The clear engine owns the back bank while busy; producer writes are dropped.
    assign wr_fire   = wr_en && wr_in_range && !clr_busy && !reset;

    // A swap needs a fully quiet cycle, so the front bank never changes under
    // an in-flight read and no write can land in the wrong bank.
    assign swap_fire = ((state == PEND) || swap_req) && !wr_en && !rd_en && !clr_busy;

`ifdef FB_CLEAR_EN
    // ------------------------------------------------------------------
    // Clear engine: busy for exactly DEPTH cycles, one word per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_busy <= 1'b0;
            clr_cnt  <= '0;
        end else if (clr_busy) begin
            if (clr_cnt == LAST_IDX) begin
                clr_busy <= 1'b0;
            end
            clr_cnt <= clr_cnt + IDX_W'(1);
        end else if (clr_req) begin
            clr_busy <= 1'b1;
            clr_cnt  <= '0;
        end
    end

    assign clr_wr = clr_busy && !reset;
`else
    logic unused_clr_req;

    assign unused_clr_req = clr_req;
    assign clr_busy       = 1'b0;
    assign clr_cnt        = '0;
    assign clr_wr         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pixel storage.
    // NOTE: the arrays have no reset branch; a reset over every word would
    // prevent RAM inference and contents are undefined until written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[back_sel][clr_cnt] <= '0;
        end else if (wr_fire) begin
            for (int c = 0; c < 3; c++) begin
                if (wr_be[c]) begin
                    mem[back_sel][wr_idx][c*CH_W +: CH_W] <= wr_data[c*CH_W +: CH_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: registered, 1-cycle latency, outputs hold when idle.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_r     <= '0;
            rd_g     <= '0;
            rd_b     <= '0;
            rd_valid <= 1'b0;
            rd_oob   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_oob   <= rd_en && !rd_in_range;
            if (rd_en) begin
                if (rd_in_range) begin
                    {rd_b, rd_g, rd_r} <= mem[front_sel][rd_idx];
                end else begin
                    {rd_b, rd_g, rd_r} <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Swap FSM. Requests in PEND are absorbed into the single pending swap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= swap_fire;
            if (swap_fire) begin
                front_sel <= ~front_sel;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (swap_req) state <= PEND;
                    PEND:    state <= PEND;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_pingpong_frame_buffer
//
// Self-checking bench for pingpong_frame_buffer (CH_W=8, DEPTH=16, ADDR_W=8).
// A reference model holds both banks as plain arrays plus the displayed-bank
// index, a pending-swap flag and a remaining-clear count, and predicts every
// output after each clock edge. Works with and without FB_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_pingpong_frame_buffer;

    localparam int CH_W   = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic [2:0]        wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [CH_W-1:0]   rd_r, rd_g, rd_b;
    logic              rd_valid, rd_oob;
    logic              swap_req, swap_ack, front_sel;
    logic              clr_req, clr_busy;

    pingpong_frame_buffer #(.CH_W(CH_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b),
        .rd_valid(rd_valid), .rd_oob(rd_oob),
        .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] m_mem [2][DEPTH];
    logic        m_front, m_pend, m_valid, m_oob, m_ack;
    logic [23:0] m_rgb;
    int          m_clr_left;   // cycles of clearing still to come
    int          ack_count;
    int          busy_cycles;

`ifdef FB_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input logic rst_i, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [23:0] wd, input logic [2:0] be, input logic re,
                         input logic [ADDR_W-1:0] ra, input logic sr, input logic cr);
        logic busy_now, fire;
        reset = rst_i; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; swap_req = sr; clr_req = cr;
        @(posedge clk);
        if (rst_i) begin
            m_front = 0; m_pend = 0; m_valid = 0; m_oob = 0; m_ack = 0;
            m_rgb = '0; m_clr_left = 0;
        end else begin
            busy_now = (m_clr_left > 0);
            fire = (m_pend || sr) && !we && !re && !busy_now;
            m_valid = re;
            m_oob   = re && (ra >= DEPTH);
            if (re) m_rgb = (ra >= DEPTH) ? 24'h0 : m_mem[m_front][ra];
            if (we && !busy_now && wa < DEPTH)
                for (int c = 0; c < 3; c++)
                    if (be[c]) m_mem[!m_front][wa][c*8 +: 8] = wd[c*8 +: 8];
            if (busy_now) begin
                m_mem[!m_front][DEPTH - m_clr_left] = 24'h0;
                m_clr_left--;
            end else if (cr && CLEAR_EN) begin
                m_clr_left = DEPTH;
            end
            m_ack = fire;
            if (fire) begin
                m_front = !m_front;
                m_pend  = 0;
            end else if (sr) begin
                m_pend = 1;
            end
        end
        #1;
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("rd_oob", 32'(rd_oob), 32'(m_oob));
        check("rd_rgb", 32'({rd_b, rd_g, rd_r}), 32'(m_rgb));
        check("swap_ack", 32'(swap_ack), 32'(m_ack));
        check("front_sel", 32'(front_sel), 32'(m_front));
        check("clr_busy", 32'(clr_busy), 32'(m_clr_left > 0));
        if (swap_ack) ack_count++;
        if (clr_busy) busy_cycles++;
    endtask

    task automatic idle();                               cycle(0,0,0,0,0,0,0,0,0); endtask
    task automatic rst();                                cycle(1,0,0,0,0,0,0,0,0); endtask
    task automatic wr(input int a, input logic [23:0] d, input logic [2:0] be);
        cycle(0,1,ADDR_W'(a),d,be,0,0,0,0);
    endtask
    task automatic rd(input int a);                      cycle(0,0,0,0,0,1,ADDR_W'(a),0,0); endtask
    task automatic swp();                                cycle(0,0,0,0,0,0,0,1,0); endtask

    initial begin
        logic f0;
        ack_count = 0; busy_cycles = 0;

        // Reset state.
        rst(); rst();
        check("rst_rgb", 32'({rd_b, rd_g, rd_r}), 32'h0);
        check("rst_front", 32'(front_sel), 32'h0);

        // Give both banks known contents.
        for (int i = 0; i < DEPTH; i++) wr(i, 24'($urandom), 3'b111);
        swp();
        for (int i = 0; i < DEPTH; i++) wr(i, 24'($urandom), 3'b111);
        swp();

        // Reset with a swap pending: it is discarded, then a read still works.
        cycle(0,0,0,0,0,1,0,1,0);
        rst();
        idle();
        check("rst_discard_front", 32'(front_sel), 32'h0);
        rd(0);
        check("rst_rd_valid", 32'(rd_valid), 32'h1);

        // Write, swap on an idle cycle, read back.
        wr(5, 24'h332211, 3'b111);
        swp();
        check("swap_ack_direct", 32'(swap_ack), 32'h1);
        check("front_after_swap", 32'(front_sel), 32'h1);
        rd(5);
        check("rd_r_5", 32'(rd_r), 32'h11);
        check("rd_g_5", 32'(rd_g), 32'h22);
        check("rd_b_5", 32'(rd_b), 32'h33);
        idle();
        check("rd_valid_pulse", 32'(rd_valid), 32'h0);

        // Per-channel enable: only G changes.
        wr(5, 24'h332211, 3'b111);
        wr(5, 24'hAABBCC, 3'b010);
        swp();
        rd(5);
        check("be_r", 32'(rd_r), 32'h11);
        check("be_g", 32'(rd_g), 32'hBB);
        check("be_b", 32'(rd_b), 32'h33);

        // Deferred swap under continuous reads, two requests -> one swap.
        idle();
        f0 = front_sel;
        ack_count = 0;
        cycle(0,0,0,0,0,1,1,1,0);
        cycle(0,0,0,0,0,1,2,0,0);
        cycle(0,0,0,0,0,1,3,1,0);
        cycle(0,0,0,0,0,1,4,0,0);
        check("defer_no_swap_yet", 32'(front_sel), 32'(f0));
        idle(); idle(); idle();
        check("defer_acks", 32'(ack_count), 32'h1);
        check("defer_front", 32'(front_sel), 32'(!f0));

        // Out-of-range write and read.
        wr(16, 24'h123456, 3'b111);
        swp();
        rd(16);
        check("oob_flag", 32'(rd_oob), 32'h1);
        check("oob_data", 32'({rd_b, rd_g, rd_r}), 32'h0);
        rd(DEPTH - 1);
        check("last_in_range", 32'(rd_oob), 32'h0);

`ifdef FB_CLEAR_EN
        // Clear the back bank, with a swap request and a write during busy.
        for (int i = 0; i < DEPTH; i++) wr(i, 24'($urandom) | 24'h1, 3'b111);
        busy_cycles = 0;
        ack_count   = 0;
        cycle(0,0,0,0,0,0,0,0,1);
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 3)      swp();
            else if (k == 5) wr(2, 24'hFFFFFF, 3'b111);
            else if (k == 7) cycle(0,0,0,0,0,0,0,0,1);
            else             idle();
            if (k < DEPTH - 1) check("clr_no_early_ack", 32'(ack_count), 32'h0);
        end
        idle();
        check("clr_busy_cycles", 32'(busy_cycles), 32'(DEPTH));
        check("clr_ack_after", 32'(ack_count), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            check("clr_zero", 32'({rd_b, rd_g, rd_r}), 32'h0);
        end
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 127) == 0),
                  ($urandom_range(0, 1) == 0),
                  ADDR_W'($urandom_range(0, DEPTH + 3)),
                  24'($urandom),
                  3'($urandom),
                  ($urandom_range(0, 2) == 0),
                  ADDR_W'($urandom_range(0, DEPTH + 3)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
